// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with a single registered result stage.
// Non-MUL ops complete on the accepting edge (one result per cycle when the
// consumer keeps out_ready high). MUL is an iterative unsigned shift-add
// multiplier taking WIDTH cycles in BUSY. It is compiled in only when the
// macro ALU_PIPE_MUL_EN is defined. Without it, op 8 behaves like a reserved op.
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v,
    output logic             err
);

    localparam logic [WIDTH:0] WLIM = (WIDTH+1)'(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t state, state_next;

    logic                     accept;
    logic                     start_mul;
    logic                     mul_last;
    logic [WIDTH-1:0]         alu_res;
    logic                     alu_c, alu_v, alu_err;
    logic [WIDTH:0]           wide;
    logic signed [WIDTH-1:0]  a_s;
    logic signed [WIDTH-1:0]  sar_res;
    logic                     big_shift;

    // Signed overflow of a+b: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    // Signed overflow of a-b: operands differ in sign, result sign differs from a.
    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    // Handshake: the result slot frees up when the consumer drains it this cycle.
    assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    // Single-cycle ops, evaluated directly from the request being accepted.
    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_err   = 1'b0;
        wide      = '0;
        a_s       = a;
        sar_res   = a_s >>> b;
        big_shift = ({1'b0, b} >= WLIM);
        case (alu_op)
            4'd0: begin
                wide    = {1'b0, a} + {1'b0, b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = add_ovf(a[WIDTH-1], b[WIDTH-1], wide[WIDTH-1]);
            end
            4'd1: begin
                wide    = {1'b0, a} - {1'b0, b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = sub_ovf(a[WIDTH-1], b[WIDTH-1], wide[WIDTH-1]);
            end
            4'd2: alu_res = big_shift ? '0 : (a >> b);
            4'd3: alu_res = big_shift ? '0 : (a << b);
            4'd4: alu_res = ~(a & b);
            4'd5: alu_res = a | b;
            4'd6: alu_res = a;
            4'd7: alu_res = big_shift ? {WIDTH{a[WIDTH-1]}} : sar_res;
`ifdef ALU_PIPE_MUL_EN
            4'd8: alu_res = '0;
`endif
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [CW-1:0]      step;
    logic [WIDTH:0]     hi_sum;
    logic [2*WIDTH-1:0] prod_next;

    assign start_mul = accept && (alu_op == 4'd8);
    assign mul_last  = (state == BUSY) && (step == CW'(WIDTH-1));

    // One shift-add step: conditionally add the multiplicand into the high
    // half, then shift {carry, hi, lo} right by one.
    always_comb begin
        hi_sum    = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        prod_next = {hi_sum, lo[WIDTH-1:1]};
    end

    // Multiplier working registers; loaded on accept, stepped while BUSY.
    always_ff @(posedge clk) begin
        if (start_mul) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            step  <= '0;
        end else if (state == BUSY) begin
            hi    <= prod_next[2*WIDTH-1:WIDTH];
            lo    <= prod_next[WIDTH-1:0];
            step  <= step + 1'b1;
        end
    end
`else
    assign start_mul = 1'b0;
    assign mul_last  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an accept in DONE chains straight into the next op.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = start_mul ? BUSY : DONE;
            BUSY: if (mul_last) state_next = DONE;
            DONE: begin
                if (accept) begin
                    state_next = start_mul ? BUSY : DONE;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result and flag register; held while waiting for the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
            z   <= 1'b0;
            n   <= 1'b0;
            c   <= 1'b0;
            v   <= 1'b0;
            err <= 1'b0;
        end else if (accept && !start_mul) begin
            out <= alu_res;
            z   <= (alu_res == '0);
            n   <= alu_res[WIDTH-1];
            c   <= alu_c;
            v   <= alu_v;
            err <= alu_err;
        end
`ifdef ALU_PIPE_MUL_EN
        else if (mul_last) begin
            out <= prod_next[WIDTH-1:0];
            z   <= (prod_next[WIDTH-1:0] == '0);
            n   <= prod_next[WIDTH-1];
            c   <= |prod_next[2*WIDTH-1:WIDTH];
            v   <= |prod_next[2*WIDTH-1:WIDTH];
            err <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (WIDTH=16): directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model built from plain integer arithmetic.
module tb_alu_pipe;

    localparam int W = 16;
`ifdef ALU_PIPE_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alu_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         z, n, c, v, err;

    int n_tests = 0;
    int n_fail  = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .z         (z),
        .n         (n),
        .c         (c),
        .v         (v),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic is_mul(input logic [3:0] op);
        return MUL_ON && (op == 4'd8);
    endfunction

    // Reference arithmetic on 64-bit integers.
    function automatic void model_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                     input logic [3:0] op, output logic [W-1:0] r,
                                     output logic fc, output logic fv, output logic fe);
        longint unsigned ua, ub, p;
        longint sa, sb, s, smax, smin;
        ua   = 64'(ia);
        ub   = 64'(ib);
        smax = (longint'(1) <<< (W-1)) - 1;
        smin = -(longint'(1) <<< (W-1));
        sa   = ia[W-1] ? longint'(ua) - (longint'(1) <<< W) : longint'(ua);
        sb   = ib[W-1] ? longint'(ub) - (longint'(1) <<< W) : longint'(ub);
        r = '0; fc = 1'b0; fv = 1'b0; fe = 1'b0;
        case (op)
            4'd0: begin p = ua + ub; r = W'(p); fc = (p >> W) != 0; s = sa + sb; fv = (s > smax) || (s < smin); end
            4'd1: begin r = W'(ua - ub); fc = ua < ub; s = sa - sb; fv = (s > smax) || (s < smin); end
            4'd2: r = (ub >= 64'(W)) ? '0 : W'(ua >> ub);
            4'd3: r = (ub >= 64'(W)) ? '0 : W'(ua << ub);
            4'd4: r = W'(~(ua & ub));
            4'd5: r = W'(ua | ub);
            4'd6: r = ia;
            4'd7: r = (ub >= 64'(W)) ? (ia[W-1] ? '1 : '0) : W'(sa >>> ub);
            4'd8: begin
                if (MUL_ON) begin
                    p = ua * ub; r = W'(p); fc = (p >> W) != 0; fv = fc;
                end else begin
                    fe = 1'b1;
                end
            end
            default: fe = 1'b1;
        endcase
    endfunction

    // Model state: what the outputs must currently show.
    bit           model_on = 1'b0;
    logic         m_valid;
    logic [W-1:0] m_out;
    logic         m_z, m_n, m_c, m_v, m_err;
    int           m_busy;
    logic [W-1:0] p_out;
    logic         p_c, p_v;

    always @(posedge clk) begin : model
        logic [W-1:0] r;
        logic fc, fv, fe;
        if (rst) begin
            model_on <= 1'b1;
            m_valid <= 1'b0; m_out <= '0; m_busy <= 0;
            m_z <= 1'b0; m_n <= 1'b0; m_c <= 1'b0; m_v <= 1'b0; m_err <= 1'b0;
        end else if (m_busy > 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
                m_valid <= 1'b1; m_out <= p_out; m_z <= (p_out == 0); m_n <= p_out[W-1];
                m_c <= p_c; m_v <= p_v; m_err <= 1'b0;
            end
        end else if (in_valid && (!m_valid || out_ready)) begin
            model_op(a, b, alu_op, r, fc, fv, fe);
            if (is_mul(alu_op)) begin
                m_busy <= W; m_valid <= 1'b0; p_out <= r; p_c <= fc; p_v <= fv;
            end else begin
                m_valid <= 1'b1; m_out <= r; m_z <= (r == 0); m_n <= r[W-1];
                m_c <= fc; m_v <= fv; m_err <= fe;
            end
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic exp_rdy;
        if (model_on) begin
            exp_rdy = !rst && (m_busy == 0) && (!m_valid || out_ready);
            chk("in_ready", in_ready, exp_rdy);
            chk("out_valid", out_valid, m_valid);
            chk("out", out, m_out);
            chk("flags_znc_v_err", {z, n, c, v, err}, {m_z, m_n, m_c, m_v, m_err});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]   ops [4] = '{4'd5, 4'd4, 4'd3, 4'd6};
    logic [W-1:0] corners [5] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001};

    initial begin
        logic [W-1:0] r;
        logic fc, fv, fe;
        int nv, nr, nbusy, first, cnt_v, sel;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_op = '0; out_ready = 1'b0;

        // Pin the model with hand-computed results.
        model_op(16'hFFFF, 16'h0001, 4'd0, r, fc, fv, fe);
        chk("model_add", {r, fc, fv, fe}, {16'h0000, 3'b100});
        model_op(16'h8000, 16'h0001, 4'd1, r, fc, fv, fe);
        chk("model_sub", {r, fc, fv, fe}, {16'h7FFF, 3'b010});
        model_op(16'h8000, 16'd20, 4'd7, r, fc, fv, fe);
        chk("model_sar", r, 16'hFFFF);
        model_op(16'h0003, 16'h0002, 4'd4, r, fc, fv, fe);
        chk("model_nand", r, 16'hFFFD);
        model_op(16'h1234, 16'h5678, 4'd12, r, fc, fv, fe);
        chk("model_reserved", {r, fe}, {16'h0000, 1'b1});

        // Reset state.
        tick(); tick();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out", out, 16'h0000);
        chk("rst_flags", {z, n, c, v, err}, 5'b00000);
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1'b1);
        tick();

        // ADD wrap to zero with carry.
        in_valid = 1'b1; alu_op = 4'd0; a = 16'hFFFF; b = 16'h0001;
        tick(); in_valid = 1'b0;
        chk("add_valid", out_valid, 1'b1);
        chk("add_out", out, 16'h0000);
        chk("add_zcv", {z, c, v}, 3'b110);
        tick();

        // SUB signed overflow, then SAR with oversized shift back-to-back.
        in_valid = 1'b1; alu_op = 4'd1; a = 16'h8000; b = 16'h0001;
        tick();
        chk("sub_out", out, 16'h7FFF);
        chk("sub_vcn", {v, c, n}, 3'b100);
        alu_op = 4'd7; a = 16'h8000; b = 16'd20;
        tick(); in_valid = 1'b0;
        chk("sar_out", out, 16'hFFFF);
        chk("sar_n", n, 1'b1);
        tick();

        // Four back-to-back ops with out_ready held high.
        nv = 0; nr = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; alu_op = ops[i]; a = 16'($urandom);
            b = (i == 2) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            tick();
            nv += int'(out_valid); nr += int'(in_ready);
        end
        in_valid = 1'b0;
        chk("b2b_valid_cycles", nv, 4);
        chk("b2b_ready_cycles", nr, 4);
        tick();

        // Consumer stalls for 5 cycles while a new request waits.
        out_ready = 1'b0; in_valid = 1'b1; alu_op = 4'd0; a = 16'h1234; b = 16'h1111;
        tick();
        alu_op = 4'd5; a = 16'hF0F0; b = 16'h0F0F;
        for (int k = 0; k < 5; k++) begin
            chk("hold_out", out, 16'h2345);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_valid", out_valid, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        tick(); in_valid = 1'b0;
        chk("after_hold_or", out, 16'hFFFF);
        tick();

`ifdef ALU_PIPE_MUL_EN
        // Multiply latency and high-half overflow flags.
        in_valid = 1'b1; alu_op = 4'd8; a = 16'h0100; b = 16'h0100;
        tick(); in_valid = 1'b0;
        nbusy = 0; first = 0;
        for (int k = 1; k <= 40 && first == 0; k++) begin
            if (out_valid) first = k;
            else if (!in_ready) nbusy++;
            if (first == 0) tick();
        end
        chk("mul_busy_cycles", nbusy, 16);
        chk("mul_valid_cycle", first, 17);
        chk("mul_out", out, 16'h0000);
        chk("mul_zcv", {z, c, v}, 3'b111);
        tick();
`endif

        // Reset five cycles into a multiply.
        in_valid = 1'b1; alu_op = 4'd8; a = 16'h1234; b = 16'h5678;
        tick(); in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt_v = 0;
        repeat (25) begin
            cnt_v += int'(out_valid);
            tick();
        end
        chk("rst_mul_no_result", cnt_v, 0);
        chk("rst_mul_out", out, 16'h0000);
        chk("rst_mul_flags", {z, n, c, v, err}, 5'b00000);

        // Reserved op after reset.
        in_valid = 1'b1; alu_op = 4'd12; a = 16'hABCD; b = 16'h1357;
        tick(); in_valid = 1'b0;
        chk("reserved_out", out, 16'h0000);
        chk("reserved_flags", {z, n, c, v, err}, 5'b10001);
        tick();

        // Randomized traffic, checked each cycle by the compare process.
        for (int k = 0; k < 800; k++) begin
            rst       = ($urandom_range(0, 149) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            sel = int'($urandom_range(0, 19));
            alu_op = (sel < 17) ? 4'(sel % 9) : 4'($urandom_range(9, 15));
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
            if (alu_op == 4'd2 || alu_op == 4'd3 || alu_op == 4'd7)
                b = 16'($urandom_range(0, 23));
            else
                b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
